// File: rtl/mdio_arbiter.sv
// Two-port round-robin arbiter in front of a single MDIO engine (port 0 = PHY config, port 1 = host).
// Define MDIO_TIMEOUT_EN to abort transactions that exceed TIMEOUT_CYCLES clocks.
module mdio_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [4:0]  addr0,
  input  logic [15:0] wdata0,
  output logic        done0,
  output logic [15:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic        we1,
  input  logic [4:0]  addr1,
  input  logic [15:0] wdata1,
  output logic        done1,
  output logic [15:0] rdata1,
  output logic        err1,
  output logic [4:0]  mdio_addr,
  output logic [15:0] mdio_wdata,
  output logic        mdio_rd_request,
  output logic        mdio_wr_request,
  input  logic        mdio_ready,
  input  logic [15:0] mdio_rd_data,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    COMPLETE
  } state_t;

  state_t state;
  logic   last_grant;
  logic   we_q;
  logic   pick;
  logic   pick_we;

  // A lone requester always wins; on a tie the port not served last wins.
  function automatic logic arbitrate(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  assign pick    = arbitrate(req0, req1, last_grant);
  assign pick_we = pick ? we1 : we0;

`ifdef MDIO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tcount;
  logic             expired;
  logic             err_q;

  assign expired = (tcount == LIMIT);
  assign err0    = err_q & ~grant;
  assign err1    = err_q & grant;
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      grant           <= 1'b0;
      busy            <= 1'b0;
      we_q            <= 1'b0;
      mdio_rd_request <= 1'b0;
      mdio_wr_request <= 1'b0;
      mdio_addr       <= '0;
      mdio_wdata      <= '0;
      done0           <= 1'b0;
      done1           <= 1'b0;
      rdata0          <= '0;
      rdata1          <= '0;
`ifdef MDIO_TIMEOUT_EN
      tcount          <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (mdio_ready && (req0 || req1)) begin
            state           <= ISSUE;
            grant           <= pick;
            last_grant      <= pick;
            busy            <= 1'b1;
            we_q            <= pick_we;
            mdio_addr       <= pick ? addr1 : addr0;
            mdio_wdata      <= pick ? wdata1 : wdata0;
            mdio_wr_request <= pick_we;
            mdio_rd_request <= ~pick_we;
`ifdef MDIO_TIMEOUT_EN
            tcount          <= '0;
`endif
          end
        end

        // Strobe stays up until the engine acknowledges by dropping ready.
        ISSUE, WAIT_BUSY: begin
`ifdef MDIO_TIMEOUT_EN
          tcount <= tcount + 1'b1;
`endif
          if (!mdio_ready) begin
            mdio_rd_request <= 1'b0;
            mdio_wr_request <= 1'b0;
            state           <= WAIT_DONE;
`ifdef MDIO_TIMEOUT_EN
          end else if (expired) begin
            mdio_rd_request <= 1'b0;
            mdio_wr_request <= 1'b0;
            state           <= COMPLETE;
            err_q           <= 1'b1;
            if (grant) done1 <= 1'b1;
            else       done0 <= 1'b1;
            if (!we_q && grant)  rdata1 <= 16'hFFFF;
            if (!we_q && !grant) rdata0 <= 16'hFFFF;
`endif
          end else begin
            state <= WAIT_BUSY;
          end
        end

        WAIT_DONE: begin
`ifdef MDIO_TIMEOUT_EN
          tcount <= tcount + 1'b1;
`endif
          if (mdio_ready) begin
            state <= COMPLETE;
            if (grant) done1 <= 1'b1;
            else       done0 <= 1'b1;
            if (!we_q && grant)  rdata1 <= mdio_rd_data;
            if (!we_q && !grant) rdata0 <= mdio_rd_data;
`ifdef MDIO_TIMEOUT_EN
          end else if (expired) begin
            state <= COMPLETE;
            err_q <= 1'b1;
            if (grant) done1 <= 1'b1;
            else       done0 <= 1'b1;
            if (!we_q && grant)  rdata1 <= 16'hFFFF;
            if (!we_q && !grant) rdata0 <= 16'hFFFF;
`endif
          end
        end

        // done pulses during this cycle; no new grant until IDLE.
        COMPLETE: begin
          state <= IDLE;
          busy  <= 1'b0;
`ifdef MDIO_TIMEOUT_EN
          err_q <= 1'b0;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Scoreboard bench for mdio_arbiter with a behavioural MDIO engine model.
module tb_mdio_arbiter;

`ifdef MDIO_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, we0, req1, we1;
  logic [4:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        done0, done1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic [4:0]  mdio_addr;
  logic [15:0] mdio_wdata;
  logic        mdio_rd_request, mdio_wr_request;
  logic        busy, grant;

  logic        eng_ready = 1'b1;
  logic [15:0] eng_rdata = 16'h0;
  logic [4:0]  eng_addr  = 5'h0;
  int          eng_left  = 0;
  int          eng_len   = 4;
  logic        eng_stuck = 1'b0;
  int          n_strobes = 0;
  logic        last_kind = 1'b0;

  always #5 clock = ~clock;

  mdio_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1), .err1(err1),
    .mdio_addr(mdio_addr), .mdio_wdata(mdio_wdata),
    .mdio_rd_request(mdio_rd_request), .mdio_wr_request(mdio_wr_request),
    .mdio_ready(eng_ready), .mdio_rd_data(eng_rdata),
    .busy(busy), .grant(grant)
  );

  function automatic logic [15:0] resp(input logic [4:0] a);
    return (a == 5'd31) ? 16'h0160 : {a, 3'b101, a, 3'b010};
  endfunction

  // Engine: accepts a strobe while ready, stays busy eng_len cycles, then returns data.
  always @(posedge clock) begin
    if (!eng_ready) begin
      if (!eng_stuck) begin
        if (eng_left <= 1) begin
          eng_ready <= 1'b1;
          eng_rdata <= resp(eng_addr);
        end else begin
          eng_left <= eng_left - 1;
        end
      end
    end else if (mdio_rd_request || mdio_wr_request) begin
      eng_ready <= 1'b0;
      eng_left  <= eng_len;
      eng_addr  <= mdio_addr;
      n_strobes <= n_strobes + 1;
      last_kind <= mdio_wr_request;
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_rdata [2];
  int          total = 0;
  int          bad = 0;
  bit          done_seen;
  int          done_port;
  int          n;
  int          base;
  int          c0, c1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push(input logic p, input logic we, input logic [4:0] a,
                      input logic [15:0] wd, input logic tmo);
    exp_t e;
    e.port  = p;
    e.we    = we;
    e.addr  = a;
    e.wdata = wd;
    e.err   = tmo;
    if (we)       e.rdata = model_rdata[p];
    else if (tmo) e.rdata = 16'hFFFF;
    else          e.rdata = resp(a);
    model_rdata[p] = e.rdata;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clock);
    done_seen = 1'b0;
    if (done0 || done1) begin
      done_seen = 1'b1;
      done_port = done1 ? 1 : 0;
      chk("done_overlap", 32'(done0 & done1), 0);
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_port", done_port, 32'(e.port));
        chk("grant", 32'(grant), 32'(e.port));
        chk("rdata", 32'(done1 ? rdata1 : rdata0), 32'(e.rdata));
        chk("err", 32'(done1 ? err1 : err0), 32'(e.err));
        chk("mdio_addr", 32'(mdio_addr), 32'(e.addr));
        chk("strobe_kind", 32'(last_kind), 32'(e.we));
        if (e.we) chk("mdio_wdata", 32'(mdio_wdata), 32'(e.wdata));
      end
    end
  endtask

  task automatic run_until_done(input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!done_seen && cnt < budget);
    if (!done_seen) chk("done_wait", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    model_rdata[0] = 16'h0;
    model_rdata[1] = 16'h0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'({done1, done0}), 0);
    chk("rst_err", 32'({err1, err0}), 0);
    chk("rst_rdata0", 32'(rdata0), 0);
    chk("rst_rdata1", 32'(rdata1), 0);
    chk("rst_addr", 32'(mdio_addr), 0);
    chk("rst_wdata", 32'(mdio_wdata), 0);
    chk("rst_strobes", 32'({mdio_rd_request, mdio_wr_request}), 0);

    // Read on port 0, engine busy 34 cycles
    eng_len = 34;
    we0 = 0; addr0 = 5'd31; wdata0 = 16'h1234; req0 = 1;
    push(1'b0, 1'b0, 5'd31, 16'h1234, 1'b0);
    tick();
    chk("rd_strobe", 32'({mdio_rd_request, mdio_wr_request}), 32'b10);
    chk("rd_addr", 32'(mdio_addr), 31);
    addr0 = 5'd5; wdata0 = 16'hBEEF;
    tick();
    tick();
    chk("rd_busy", 32'(busy), 1);
    chk("rd_strobe_off", 32'(mdio_rd_request), 0);
    run_until_done(200, n);
    req0 = 0;
    chk("rd_latency", n + 3, 37);
    chk("rd_strobe_count", n_strobes, 1);
    repeat (5) tick();
    chk("rdata0_hold", 32'(rdata0), 32'h0160);

    // Write on port 1
    eng_len = 5;
    we1 = 1; addr1 = 5'd9; wdata1 = 16'h0200; req1 = 1;
    push(1'b1, 1'b1, 5'd9, 16'h0200, 1'b0);
    tick();
    chk("wr_strobe", 32'({mdio_rd_request, mdio_wr_request}), 32'b01);
    chk("wr_addr", 32'(mdio_addr), 9);
    chk("wr_wdata", 32'(mdio_wdata), 32'h0200);
    run_until_done(100, n);
    req1 = 0;
    chk("wr_latency", n + 1, 8);
    chk("wr_rdata1", 32'(rdata1), 0);
    chk("wr_strobe_count", n_strobes, 2);

    // Contention after reset: expect 0,1,0,1,0,1
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_rdata[0] = 16'h0;
    model_rdata[1] = 16'h0;
    eng_len = 3;
    we0 = 0; addr0 = 5'd3; we1 = 0; addr1 = 5'd4;
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 1'b0, 5'd3, 16'h0, 1'b0);
      push(1'b1, 1'b0, 5'd4, 16'h0, 1'b0);
    end
    req0 = 1; req1 = 1;
    c0 = 0; c1 = 0;
    for (int k = 0; k < 6; k++) begin
      run_until_done(100, n);
      if (done_seen) begin
        if (done_port == 0) begin
          c0++;
          if (c0 == 3) req0 = 0;
        end else begin
          c1++;
          if (c1 == 3) req1 = 0;
        end
      end
    end
    req0 = 0; req1 = 0;
    repeat (5) tick();
    chk("cont_left", sb.size(), 0);

    // Request dropped while waiting for the engine to go busy
    eng_len = 10;
    base = n_strobes;
    we1 = 1; addr1 = 5'd12; wdata1 = 16'hA5A5; req1 = 1;
    push(1'b1, 1'b1, 5'd12, 16'hA5A5, 1'b0);
    tick();
    tick();
    req1 = 0;
    run_until_done(100, n);
    repeat (20) tick();
    chk("drop_strobes", n_strobes, base + 1);
    chk("drop_busy", 32'(busy), 0);

    // Reset while waiting for the engine to finish
    eng_len = 30;
    base = n_strobes;
    we0 = 0; addr0 = 5'd7; req0 = 1;
    push(1'b0, 1'b0, 5'd7, 16'h0, 1'b0);
    repeat (5) tick();
    chk("rw_busy", 32'(busy), 1);
    eng_stuck = 1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sb.delete();
    model_rdata[0] = 16'h0;
    model_rdata[1] = 16'h0;
    chk("rw_no_done", 32'({done1, done0}), 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rw_no_grant", 32'(busy), 0);
    end
    chk("rw_strobes", n_strobes, base + 1);
    push(1'b0, 1'b0, 5'd7, 16'h0, 1'b0);
    eng_stuck = 0;
    run_until_done(200, n);
    req0 = 0;
    chk("rw_restrobes", n_strobes, base + 2);

`ifdef MDIO_TIMEOUT_EN
    // Engine never completes: timeout after 16 clocks
    tick();
    eng_stuck = 1;
    we0 = 0; addr0 = 5'd2; req0 = 1;
    push(1'b0, 1'b0, 5'd2, 16'h0, 1'b1);
    run_until_done(100, n);
    req0 = 0;
    chk("to_latency", n, 17);
    tick();
    chk("to_idle", 32'(busy), 0);
    eng_stuck = 0;
    repeat (40) tick();
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_arbiter.md
MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 The parameter list SHALL be, one per line: TIMEOUT_CYCLES, default 4096, clocks allowed for one MDIO transaction before abort (used only with MDIO_TIMEOUT_EN).
REQ-002 Port: clock  input  1  MDIO-domain clock (2.5 MHz); all logic on the rising edge.
REQ-003 Port: reset_n  input  1  reset; synchronous, active-low.
REQ-004 Port, requester n = 0 (PHY config) and n = 1 (host register access), one per line: reqN  input  1  transaction request, held until doneN.
REQ-005 Port: weN  input  1  1 = write, 0 = read; stable while reqN is high.
REQ-006 Port: addrN  input  5  PHY register address; stable while reqN is high.
REQ-007 Port: wdataN  input  16  write data; stable while reqN is high.
REQ-008 Port: doneN  output  1  single-cycle completion pulse.
REQ-009 Port: rdataN  output  16  read data, valid when doneN is high, held until the next doneN.
REQ-010 Port: errN  output  1  timeout flag, valid with doneN.
REQ-011 Port: mdio_addr  output  5  address to the MDIO engine.
REQ-012 Port: mdio_wdata  output  16  write data to the MDIO engine.
REQ-013 Port: mdio_rd_request  output  1  read strobe to the MDIO engine.
REQ-014 Port: mdio_wr_request  output  1  write strobe to the MDIO engine.
REQ-015 Port: mdio_ready  input  1  engine idle; drops after a strobe and returns high when the transaction completes.
REQ-016 Port: mdio_rd_data  input  16  engine read result, valid when mdio_ready returns high.
REQ-017 Port: busy  output  1  high in any state other than IDLE.
REQ-018 Port: grant  output  1  index of the port being served.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and COMPLETE.
REQ-020 IDLE SHALL grant only when mdio_ready=1 and at least one reqN=1; on a grant it latches the port's we/addr/wdata into mdio_addr/mdio_wdata and moves to ISSUE on the next cycle.
REQ-021 Arbitration SHALL be round-robin: when both requests are high, the port not granted last wins; when one request is high, that port wins regardless of history.
REQ-022 ISSUE SHALL assert mdio_wr_request (we=1) or mdio_rd_request (we=0) and hold it until mdio_ready=0, then deassert it and enter WAIT_DONE.
REQ-023 WAIT_DONE SHALL wait for mdio_ready=1, then latch mdio_rd_data into rdata of the granted port (reads only) and enter COMPLETE.
REQ-024 COMPLETE SHALL pulse doneN of the granted port for exactly one cycle and return to IDLE.
REQ-025 After doneN, reqN still high SHALL be treated as a new request; no grant SHALL occur in the COMPLETE cycle itself.
REQ-026 rdataN of a write transaction SHALL be left unchanged.
REQ-027 The latency from grant to doneN SHALL be 2 cycles plus the engine's ready-low time, with no idle cycles added by the arbiter.
REQ-028 The addr/we/wdata inputs SHALL be sampled only at grant; changes to them afterwards SHALL be ignored.
REQ-029 A reqN dropped before its doneN SHALL be ignored; the transaction SHALL run to completion and doneN SHALL still pulse.

Reset
REQ-030 reset_n=0 SHALL force state IDLE, last-grant = 1 (so port 0 wins the first tie), mdio_*_request=0, doneN=0, errN=0, rdataN=0, mdio_addr=0, mdio_wdata=0, busy=0, grant=0.
REQ-031 A reset asserted mid-transaction SHALL abort the transaction without any doneN pulse; after reset release, no grant SHALL occur until mdio_ready=1.

Configuration
REQ-032 With macro MDIO_TIMEOUT_EN defined, a counter SHALL run in ISSUE and WAIT_DONE.
REQ-033 If that counter reaches TIMEOUT_CYCLES, the arbiter SHALL deassert the strobes, go to COMPLETE, return rdataN=16'hFFFF for reads, and assert errN with doneN.
REQ-034 Without MDIO_TIMEOUT_EN, the arbiter SHALL wait for the engine indefinitely, errN SHALL be tied 0, and no counter logic SHALL be present.

Verification
REQ-035 Read: req0 read with addr0=31, engine busy 34 cycles, returns 16'h0160 -> one mdio_rd_request, done0 pulses once with rdata0=16'h0160, err0=0.
REQ-036 Write: req1 write with addr1=9, wdata1=16'h0200 -> mdio_wr_request with mdio_addr=9 and mdio_wdata=16'h0200; done1 pulses; rdata1 unchanged.
REQ-037 Contention: req0 and req1 high together after reset, each held high for 3 transactions -> grant order 0,1,0,1,0,1.
REQ-038 Reset in WAIT_DONE: reset_n low for 1 cycle -> no done pulse; with mdio_ready held 0 for 10 more cycles, no grant occurs until ready=1.
REQ-039 With MDIO_TIMEOUT_EN and TIMEOUT_CYCLES=16: mdio_ready stuck 0 on a read -> done pulses with err=1 and rdata=16'hFFFF, and the FSM returns to IDLE.
REQ-040 Dropped request: req1 dropped in WAIT_BUSY -> the transaction completes, done1 pulses, and no second grant occurs.
